// File: rtl/comp_seq.sv
`default_nettype none
// ============================================================================
// Module      : comp_seq
// Description : Digit-serial magnitude comparator. Compares two WIDTH-bit
//               operands DIGIT bits per clock, most significant digit first.
//               It stops at the first differing digit. Signed compares are
//               reduced to unsigned ones by inverting the sign bit of both
//               operands when they are captured (offset-binary).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     : operand width in bits; must be a multiple of DIGIT
//   DIGIT     : bits examined per clock
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   start     : request a comparison (honoured only while idle)
//   is_signed : 1 = two's-complement compare, 0 = unsigned
//   a, b      : operands, sampled on the accepting edge only
//   busy      : high while a comparison is in progress
//   done      : one-cycle pulse marking a new result
//   y         : {a<b, a>b, a==b}; 000 only between reset and first result
//   cycles    : digits examined for the last result
// ============================================================================
module comp_seq #(
    parameter int WIDTH = 10,
    parameter int DIGIT = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              is_signed,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    output logic                              busy,
    output logic                              done,
    output logic [2:0]                        y,
    output logic [$clog2(WIDTH/DIGIT):0]      cycles
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Result encodings for y.
    localparam logic [2:0] Y_EQ = 3'b001;
    localparam logic [2:0] Y_GT = 3'b010;
    localparam logic [2:0] Y_LT = 3'b100;

    // Reject parameter sets that would leave a partial digit.
    if ((WIDTH % DIGIT) != 0 || DIGIT < 1 || WIDTH < 2) begin : g_bad_params
        $error("comp_seq: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [KW-1:0]       k_q;
    logic                busy_q;
    logic                done_q;
    logic [2:0]          y_q;
    logic [CW-1:0]       cycles_q;

    // Inverting the sign bit maps two's complement onto offset binary, so
    // the digit walk below only ever has to order unsigned values.
    // The flip is folded into the stored operands, so is_signed itself
    // never needs to be kept.
    logic [WIDTH-1:0]    sign_flip;
    assign sign_flip = {is_signed, {(WIDTH-1){1'b0}}};

    // Split the captured operands into digits so the walk can index them.
    logic [DIGIT-1:0]    a_dig [NDIG];
    logic [DIGIT-1:0]    b_dig [NDIG];

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        assign a_dig[gi] = a_q[gi*DIGIT +: DIGIT];
        assign b_dig[gi] = b_q[gi*DIGIT +: DIGIT];
    end

    logic [DIGIT-1:0]    a_sel;
    logic [DIGIT-1:0]    b_sel;
    logic                dig_ne;
    logic                dig_gt;
    logic                k_zero;

    always_comb begin
        a_sel  = a_dig[k_q];
        b_sel  = b_dig[k_q];
        dig_ne = (a_sel != b_sel);
        dig_gt = (a_sel >  b_sel);
        k_zero = (k_q == '0);
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. busy is set on the accepting
    // edge and cleared on the result edge. done is set only on the result
    // edge, so the two are never high together.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_q      <= '0;
            cycles_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Also reached in the done cycle, which lets a new
                    // start go back-to-back with the previous result.
                    if (start) begin
                        a_q     <= a ^ sign_flip;
                        b_q     <= b ^ sign_flip;
                        k_q     <= KW'(NDIG - 1);
                        busy_q  <= 1'b1;
                        state_q <= ST_CMP;
                    end
                end

                ST_CMP: begin
                    if (dig_ne) begin
                        // First differing digit decides; stop early.
                        y_q      <= dig_gt ? Y_GT : Y_LT;
                        cycles_q <= CW'(NDIG - int'(k_q));
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else if (!k_zero) begin
                        k_q <= k_q - KW'(1);
                    end else begin
                        // All digits matched.
                        y_q      <= Y_EQ;
                        cycles_q <= CW'(NDIG);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign y      = y_q;
    assign cycles = cycles_q;

    // ------------------------------------------------------------------
    // Design invariants
    // ------------------------------------------------------------------
    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
        !(busy_q && done_q));

    a_k_in_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_CMP) |-> (int'(k_q) < NDIG));

    a_busy_tracks_state: assert property (@(posedge clk) disable iff (rst)
        busy_q == (state_q == ST_CMP));

endmodule

`default_nettype wire
